// File: rtl/instr_sequencer_if.sv
// Program-memory fetch channel between instr_sequencer (master) and the
// instruction memory (slave). A fetch completes in the cycle where
// mem_req and mem_ack are both high; mem_rdata is valid in that cycle.
interface instr_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [5:0]        mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle control sequencer for the lab CPU.
// Fetches 6-bit instructions (opc = [5:3], arg = [2:0]) over a req/ack
// channel, holds them in the instruction register for the decoder, pulses
// register/accumulator clock enables for one cycle and keeps the PC.
// Each instruction runs FETCH -> DECODE -> EXEC; HALT parks the machine.
// Optional build macro INSTR_SEQ_STEP_EN adds a 'step' input and a
// STEP_WAIT state entered after every non-HALT EXEC (single-step mode).
module instr_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int NUM_REGS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
`ifdef INSTR_SEQ_STEP_EN
  input  logic                step,
`endif
  instr_sequencer_if.master   mem,
  output logic [5:0]          instruction,
  output logic [NUM_REGS-1:0] ce_reg,
  output logic                ce_acc,
  output logic [2:0]          alu_op,
  output logic [ADDR_W-1:0]   pc,
  output logic                busy,
  output logic                halted,
  output logic                illegal
);

  localparam logic [2:0] OPC_NOP  = 3'b000;
  localparam logic [2:0] OPC_LDR  = 3'b001;
  localparam logic [2:0] OPC_ALU  = 3'b010;
  localparam logic [2:0] OPC_JMP  = 3'b011;
  localparam logic [2:0] OPC_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
`ifdef INSTR_SEQ_STEP_EN
    ,
    S_STEP_WAIT
`endif
  } state_t;

`ifdef INSTR_SEQ_STEP_EN
  localparam state_t S_AFTER_EXEC = S_STEP_WAIT;
`else
  localparam state_t S_AFTER_EXEC = S_FETCH;
`endif

  state_t     state;
  state_t     state_nxt;
  logic [2:0] opc;
  logic [2:0] arg;
  logic       ill_now;

  // Reserved opcodes and LDR to a non-existent register are illegal.
  function automatic logic is_illegal(input logic [5:0] ins);
    case (ins[5:3])
      OPC_NOP, OPC_ALU, OPC_JMP, OPC_HALT: return 1'b0;
      OPC_LDR:                             return (int'(ins[2:0]) >= NUM_REGS);
      default:                             return 1'b1;
    endcase
  endfunction

  // PC after EXEC: JMP adds the sign-extended 3-bit offset (-4..+3),
  // HALT holds, everything else steps by one. Wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] cur,
                                                input logic [5:0]        ins);
    logic signed [2:0]        off_s;
    logic signed [ADDR_W-1:0] off_ext;
    off_s   = ins[2:0];
    off_ext = off_s;
    case (ins[5:3])
      OPC_JMP:  return cur + $unsigned(off_ext);
      OPC_HALT: return cur;
      default:  return cur + ADDR_W'(1);
    endcase
  endfunction

  assign opc     = instruction[5:3];
  assign arg     = instruction[2:0];
  assign ill_now = is_illegal(instruction);

  // Fetch channel and status flags decode straight from the state, so an
  // async reset drops mem_req without waiting for a clock edge.
  assign mem.mem_req  = (state == S_FETCH);
  assign mem.mem_addr = pc;
  assign busy         = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
  assign halted       = (state == S_HALT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and the EXEC-only enable pulses.
  always_comb begin
    state_nxt = state;
    ce_reg    = '0;
    ce_acc    = 1'b0;
    alu_op    = 3'd0;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_FETCH:  if (mem.mem_ack) state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        if (opc == OPC_LDR && !ill_now) ce_reg = NUM_REGS'(1) << arg;
        if (opc == OPC_ALU) begin
          ce_acc = 1'b1;
          alu_op = arg;
        end
        state_nxt = (opc == OPC_HALT) ? S_HALT : S_AFTER_EXEC;
      end
      S_HALT:   if (start) state_nxt = S_FETCH;
`ifdef INSTR_SEQ_STEP_EN
      S_STEP_WAIT: if (step) state_nxt = S_FETCH;
`endif
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Program counter, instruction register and sticky illegal flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= '0;
      instruction <= '0;
      illegal     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc      <= '0;
            illegal <= 1'b0;
          end
        end
        S_FETCH: begin
          if (mem.mem_ack) instruction <= mem.mem_rdata;
        end
        S_EXEC: begin
          pc <= next_pc(pc, instruction);
          if (ill_now) illegal <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
